display_scan_controller: RTL and testbench

- Time-multiplexing scan controller for the 4-digit, 8-segment display driven by TOP (segment bus plus digit selects).
- Shares the single segment bus between the four digits in round-robin slots.
- Inserts dead-time between digits to prevent ghosting and PWM-dims each slot from a brightness input.
- Double-buffers the displayed value so updates land only on frame boundaries, which prevents tearing.

---
 rtl/display_scan_controller.sv | 152 +++++++++++++++
 tb/tb_display_scan_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit, 8-segment display with
// per-slot dead-time, PWM brightness, leading-zero blanking and frame-aligned updates.
module display_scan_controller #(
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter int unsigned STEP_CYCLES    = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_load,
  input  logic        i_lzb,
  input  logic [3:0]  i_brightness,
  output logic [7:0]  o_LED,
  output logic [3:0]  o_digitSelect,
  output logic        o_frameStart,
  output logic        o_pending
);

  localparam int unsigned SLOT_CYCLES = DEAD_CYCLES + 15 * STEP_CYCLES;
  localparam int unsigned CW          = $clog2(SLOT_CYCLES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    b_q, b_d;
  logic          frame_start_d;

  logic [15:0]   active_val, pend_val;
  logic [3:0]    active_dp, pend_dp;
  logic          pend_flag;

  logic          last_cnt, boundary, lit;
  logic [3:0]    eff_b, nz, higher_nz, dp_hold, blank, nibble;
  logic [31:0]   cnt_ext, on_end;
  logic [7:0]    led_d;
  logic [3:0]    dig_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan sequencing; the first cycle after reset parks at digit 0 / counter 0 so frameStart can flag it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    b_d           = b_q;
    last_cnt      = (cnt_q == CW'(SLOT_CYCLES - 1));
    boundary      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        boundary = last_cnt && (idx_q == 2'd3);
        if (last_cnt) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cnt_q == '0) begin
      b_d = i_brightness;
    end
    frame_start_d = (idx_d == 2'd0) && (cnt_d == '0);
  end

  // Lit window, blanking and segment decode for the current slot.
  always_comb begin
    eff_b   = (cnt_q == '0) ? i_brightness : b_q;
    cnt_ext = 32'(cnt_q);
    on_end  = DEAD_CYCLES + 32'(eff_b) * STEP_CYCLES;
    for (int n = 0; n < 4; n++) begin
      nz[n] = |active_val[4*n +: 4];
    end
    higher_nz = {nz[3], nz[3] | nz[2], nz[3] | nz[2] | nz[1], 1'b1};
    dp_hold   = {active_dp[3], |active_dp[3:2], |active_dp[3:1], |active_dp[3:0]};
    blank     = {4{i_lzb}} & ~higher_nz & ~dp_hold;
    nibble    = active_val[{idx_q, 2'b00} +: 4];
    lit       = (state_q == ST_SCAN) && !blank[idx_q] &&
                (cnt_ext >= DEAD_CYCLES) && (cnt_ext < on_end);
    led_d     = lit ? {active_dp[idx_q], seg_decode(nibble)} : 8'h00;
    dig_d     = lit ? (4'b0001 << idx_q) : 4'b0000;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      b_q           <= '0;
      active_val    <= '0;
      active_dp     <= '0;
      pend_val      <= '0;
      pend_dp       <= '0;
      pend_flag     <= 1'b0;
      o_LED         <= {8{SEG_ACTIVE_LOW}};
      o_digitSelect <= {4{DIG_ACTIVE_LOW}};
      o_frameStart  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      b_q           <= b_d;
      o_LED         <= led_d ^ {8{SEG_ACTIVE_LOW}};
      o_digitSelect <= dig_d ^ {4{DIG_ACTIVE_LOW}};
      o_frameStart  <= frame_start_d;
      // A load coinciding with the boundary bypasses the pending buffer.
      if (boundary) begin
        if (i_load) begin
          active_val <= i_value;
          active_dp  <= i_dp;
        end else if (pend_flag) begin
          active_val <= pend_val;
          active_dp  <= pend_dp;
        end
        pend_flag <= 1'b0;
      end else if (i_load) begin
        pend_val  <= i_value;
        pend_dp   <= i_dp;
        pend_flag <= 1'b1;
      end
    end
  end

  assign o_pending = pend_flag;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: frame-level checks of digit order,
// segment codes, on-time, blanking, double buffering and reset.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lzb;
  logic [3:0]  brightness;
  logic [7:0]  led;
  logic [3:0]  dsel_n;
  logic        frame_start;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  int         lit_cnt [4];
  logic [7:0] seg_seen [4];
  int         fs_cnt, fs_pos, idle_bad, multi_bad, pend_cnt;

  always #5 clk = ~clk;

  display_scan_controller dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_value      (value),
    .i_dp         (dp),
    .i_load       (load),
    .i_lzb        (lzb),
    .i_brightness (brightness),
    .o_LED        (led),
    .o_digitSelect(dsel_n),
    .o_frameStart (frame_start),
    .o_pending    (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observes one 68-cycle frame starting from a cycle where o_frameStart was high.
  task automatic run_frame(input int la, input logic [15:0] va, input logic [3:0] da,
                           input int lb, input logic [15:0] vb, input logic [3:0] db);
    logic [3:0] act;
    for (int d = 0; d < 4; d++) begin
      lit_cnt[d]  = 0;
      seg_seen[d] = 8'h00;
    end
    fs_cnt = 0; fs_pos = -1; idle_bad = 0; multi_bad = 0; pend_cnt = 0;
    for (int i = 0; i < 68; i++) begin
      @(negedge clk);
      act = ~dsel_n;
      if ($countones(act) > 1) multi_bad++;
      if (act == 4'h0 && led !== 8'hFF) idle_bad++;
      for (int d = 0; d < 4; d++) begin
        if (act[d]) begin
          lit_cnt[d]++;
          seg_seen[d] = led;
        end
      end
      if (frame_start) begin
        fs_cnt++;
        fs_pos = i;
      end
      if (pending) pend_cnt++;
      load = 1'b0;
      if (i == la) begin
        load = 1'b1; value = va; dp = da;
      end
      if (i == lb) begin
        load = 1'b1; value = vb; dp = db;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int l0, input int l1, input int l2,
                             input int l3, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input int pend_exp);
    int         lexp [4];
    logic [7:0] sexp [4];
    lexp = '{l0, l1, l2, l3};
    sexp = '{s0, s1, s2, s3};
    check({tag, "_fs_cnt"}, 32'(fs_cnt), 32'd1);
    check({tag, "_fs_pos"}, 32'(fs_pos), 32'd67);
    check({tag, "_idle_led"}, 32'(idle_bad), 32'd0);
    check({tag, "_onehot"}, 32'(multi_bad), 32'd0);
    check({tag, "_pend_cycles"}, 32'(pend_cnt), 32'(pend_exp));
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_lit%0d", tag, d), 32'(lit_cnt[d]), 32'(lexp[d]));
      if (lexp[d] > 0) check($sformatf("%s_seg%0d", tag, d), 32'(seg_seen[d]), 32'(sexp[d]));
    end
  endtask

  initial begin
    rst = 1'b1; value = '0; dp = '0; load = 1'b0; lzb = 1'b0; brightness = 4'd15;
    repeat (10) @(negedge clk);
    check("rst_led", 32'(led), 32'hFF);
    check("rst_dsel", 32'(dsel_n), 32'hF);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_fs", 32'(frame_start), 32'd1);
    check("rel_led", 32'(led), 32'hFF);

    // Mid-frame load of 0x1234 while zeros are still displayed.
    run_frame(30, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_zero", 15, 15, 15, 15, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 36);
    run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_1234", 15, 15, 15, 15, 8'h99, 8'hB0, 8'hA4, 8'hF9, 0);

    // Boundary bypass load of 0x0007 with blanking on.
    lzb = 1'b1;
    run_frame(66, 16'h0007, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_bypass", 15, 15, 15, 15, 8'h99, 8'hB0, 8'hA4, 8'hF9, 0);
    run_frame(66, 16'h0007, 4'b0010, -1, 16'h0, 4'h0);
    check_frame("f_lzb", 15, 0, 0, 0, 8'hF8, 8'h00, 8'h00, 8'h00, 0);
    run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_lzb_dp", 15, 15, 0, 0, 8'hF8, 8'h40, 8'h00, 8'h00, 0);

    // Dimming: brightness 4, then dark.
    lzb = 1'b0; brightness = 4'd4;
    run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_b4", 4, 4, 4, 4, 8'hF8, 8'h40, 8'hC0, 8'hC0, 0);
    brightness = 4'd0;
    run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_b0", 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // Two loads within one frame: last one wins.
    brightness = 4'd15;
    run_frame(5, 16'h1111, 4'h0, 20, 16'h2222, 4'h0);
    check_frame("f_two_ld", 15, 15, 15, 15, 8'hF8, 8'h40, 8'hC0, 8'hC0, 61);
    run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_2222", 15, 15, 15, 15, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 0);

    // Reset mid-slot with a pending load.
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      load = (i == 10);
      if (i == 10) value = 16'h5555;
    end
    check("mid_pend_before", 32'(pending), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_led", 32'(led), 32'hFF);
    check("mid_rst_dsel", 32'(dsel_n), 32'hF);
    check("mid_rst_fs", 32'(frame_start), 32'd0);
    check("mid_rst_pend", 32'(pending), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_fs", 32'(frame_start), 32'd1);
    run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f_after_rst", 15, 15, 15, 15, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
